// File: rtl/multi_debounce_edge_detect.sv
// N-channel input conditioner: synchronizer, timed debounce FSM and rise/fall pulse per channel.
// Optional macro DEBOUNCE_SYNC_3FF_EN selects a 3-flop synchronizer instead of 2 flops.
module multi_debounce_edge_detect #(
    parameter int par_count         = 4,
    parameter int par_T_stable_bits = 20,
    parameter int par_T_stable_val  = 500000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [par_count-1:0] i_x,
    output logic [par_count-1:0] o_level,
    output logic [par_count-1:0] o_rise,
    output logic [par_count-1:0] o_fall
);

    // Bad parameter sets stop elaboration rather than building a debouncer that never settles.
    if (par_T_stable_val < 2 ||
        (64'(par_T_stable_val) - 64'd1) >= (64'd1 << par_T_stable_bits)) begin : g_param_check
        $fatal(1, "multi_debounce_edge_detect: par_T_stable_val out of range for par_T_stable_bits");
    end
    if (par_count < 1 || par_count > 16) begin : g_count_check
        $fatal(1, "multi_debounce_edge_detect: par_count must be 1..16");
    end

    localparam logic [par_T_stable_bits-1:0] T_LAST = par_T_stable_bits'(par_T_stable_val - 1);

    // Gray-coded so every legal transition flips exactly one state bit.
    typedef enum logic [1:0] {
        ST_LOW       = 2'b00,
        ST_RISE_WAIT = 2'b01,
        ST_HIGH      = 2'b11,
        ST_FALL_WAIT = 2'b10
    } state_t;

    logic [par_count-1:0] s_sync;

`ifdef DEBOUNCE_SYNC_3FF_EN
    logic [par_count-1:0] s_meta0;
    logic [par_count-1:0] s_meta1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s_meta0 <= '0;
            s_meta1 <= '0;
            s_sync  <= '0;
        end else begin
            s_meta0 <= i_x;
            s_meta1 <= s_meta0;
            s_sync  <= s_meta1;
        end
    end
`else
    logic [par_count-1:0] s_meta0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s_meta0 <= '0;
            s_sync  <= '0;
        end else begin
            s_meta0 <= i_x;
            s_sync  <= s_meta0;
        end
    end
`endif

    for (genvar g = 0; g < par_count; g++) begin : g_ch
        state_t                       s_state;
        state_t                       s_state_nxt;
        logic [par_T_stable_bits-1:0] s_timer;
        logic                         s_rise_q;
        logic                         s_fall_q;
        logic                         s_rise_commit;
        logic                         s_fall_commit;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                s_state  <= ST_LOW;
                s_timer  <= '0;
                s_rise_q <= 1'b0;
                s_fall_q <= 1'b0;
            end else begin
                s_state  <= s_state_nxt;
                s_rise_q <= s_rise_commit;
                s_fall_q <= s_fall_commit;
                if (s_state_nxt != s_state) begin
                    s_timer <= '0;
                end else if (s_timer < T_LAST) begin
                    s_timer <= s_timer + par_T_stable_bits'(1);
                end
            end
        end

        // The synchronized input is tested before the timer, so a revert beats a timeout.
        always_comb begin
            s_state_nxt   = s_state;
            s_rise_commit = 1'b0;
            s_fall_commit = 1'b0;
            case (s_state)
                ST_LOW: begin
                    if (s_sync[g]) s_state_nxt = ST_RISE_WAIT;
                end
                ST_RISE_WAIT: begin
                    if (!s_sync[g]) begin
                        s_state_nxt = ST_LOW;
                    end else if (s_timer >= T_LAST) begin
                        s_state_nxt   = ST_HIGH;
                        s_rise_commit = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!s_sync[g]) s_state_nxt = ST_FALL_WAIT;
                end
                ST_FALL_WAIT: begin
                    if (s_sync[g]) begin
                        s_state_nxt = ST_HIGH;
                    end else if (s_timer >= T_LAST) begin
                        s_state_nxt   = ST_LOW;
                        s_fall_commit = 1'b1;
                    end
                end
                default: s_state_nxt = ST_LOW;
            endcase
        end

        assign o_level[g] = (s_state == ST_HIGH) || (s_state == ST_FALL_WAIT);
        assign o_rise[g]  = s_rise_q;
        assign o_fall[g]  = s_fall_q;
    end

endmodule

// File: tb/tb_multi_debounce_edge_detect.sv
// Bench for multi_debounce_edge_detect: directed scenarios plus random input activity,
// checked every cycle against a run-length model of the debounce rules.
module tb_multi_debounce_edge_detect;

    localparam int NCH = 4;
    localparam int TB  = 4;
    localparam int TV  = 8;
`ifdef DEBOUNCE_SYNC_3FF_EN
    localparam int SD  = 3;
`else
    localparam int SD  = 2;
`endif
    localparam int LAT = SD + TV + 1;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic [NCH-1:0] i_x   = '0;
    logic [NCH-1:0] o_level;
    logic [NCH-1:0] o_rise;
    logic [NCH-1:0] o_fall;

    int checks   = 0;
    int failures = 0;

    // Model: a level flips once the synchronized input has disagreed with it on TV+1 consecutive edges.
    logic [NCH-1:0] m_hist [SD];
    logic [NCH-1:0] m_level;
    logic [NCH-1:0] m_rise;
    logic [NCH-1:0] m_fall;
    int             m_run [NCH];
    int             rise_cnt [NCH];

    multi_debounce_edge_detect #(
        .par_count        (NCH),
        .par_T_stable_bits(TB),
        .par_T_stable_val (TV)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_x    (i_x),
        .o_level(o_level),
        .o_rise (o_rise),
        .o_fall (o_fall)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic [NCH-1:0] seen;
        m_rise = '0;
        m_fall = '0;
        if (i_rst) begin
            for (int i = 0; i < SD; i++) m_hist[i] = '0;
            for (int c = 0; c < NCH; c++) m_run[c] = 0;
            m_level = '0;
        end else begin
            seen = m_hist[SD-1];
            for (int c = 0; c < NCH; c++) begin
                if (seen[c] != m_level[c]) begin
                    m_run[c]++;
                    if (m_run[c] == TV + 1) begin
                        m_level[c] = seen[c];
                        if (seen[c]) m_rise[c] = 1'b1;
                        else         m_fall[c] = 1'b1;
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            for (int i = SD - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = i_x;
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        model_update();
        #1;
        chk("level", 32'(o_level), 32'(m_level));
        chk("rise", 32'(o_rise), 32'(m_rise));
        chk("fall", 32'(o_fall), 32'(m_fall));
        chk("rise_fall_excl", 32'(o_rise & o_fall), 32'd0);
        for (int c = 0; c < NCH; c++) rise_cnt[c] += int'(o_rise[c]);
    endtask

    // Steps until the chosen pulse appears on channel ch; 0 means it never came within the budget.
    task automatic wait_pulse(input int ch, input bit want_rise, output int n);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (want_rise ? o_rise[ch] : o_fall[ch]) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic steps(input int cnt);
        for (int k = 0; k < cnt; k++) step();
    endtask

    initial begin
        int n;
        for (int c = 0; c < NCH; c++) rise_cnt[c] = 0;

        // 1: reset held three cycles
        i_rst = 1'b1;
        i_x   = '0;
        steps(3);
        chk("reset_level", 32'(o_level), 32'd0);
        chk("reset_rise", 32'(o_rise), 32'd0);
        chk("reset_fall", 32'(o_fall), 32'd0);
        i_rst = 1'b0;
        steps(3);
        chk("post_reset_level", 32'(o_level), 32'd0);

        // 2: single channel rise and fall latency
        i_x = 4'b0001;
        wait_pulse(0, 1'b1, n);
        chk("rise_latency_ch0", 32'(n), 32'(LAT));
        chk("rise_only_ch0", 32'(o_rise), 32'h1);
        i_x = 4'b0000;
        wait_pulse(0, 1'b0, n);
        chk("fall_latency_ch0", 32'(n), 32'(LAT));
        chk("fall_only_ch0", 32'(o_fall), 32'h1);
        steps(3);

        // 3: bounce rejected, then accepted once the last high is held
        rise_cnt[1] = 0;
        i_x = 4'b0010; steps(5);
        i_x = 4'b0000; steps(2);
        i_x = 4'b0010; steps(5);
        i_x = 4'b0000; steps(15);
        chk("bounce_no_rise", 32'(rise_cnt[1]), 32'd0);
        chk("bounce_level", 32'(o_level), 32'd0);
        i_x = 4'b0010; steps(5);
        i_x = 4'b0000; steps(2);
        i_x = 4'b0010; steps(20);
        chk("bounce_one_rise", 32'(rise_cnt[1]), 32'd1);
        i_x = 4'b0000; steps(20);

        // 4: all channels together
        i_x = 4'b1111;
        wait_pulse(3, 1'b1, n);
        chk("rise_latency_all", 32'(n), 32'(LAT));
        chk("rise_all_together", 32'(o_rise), 32'hF);
        chk("level_all", 32'(o_level), 32'hF);
        steps(4);

        // 5: reset mid-hold, input stays high and is re-qualified
        i_rst = 1'b1;
        steps(2);
        chk("midreset_level", 32'(o_level), 32'd0);
        i_rst = 1'b0;
        wait_pulse(2, 1'b1, n);
        chk("rise_after_reset", 32'(n), 32'(LAT));
        chk("rise_after_reset_all", 32'(o_rise), 32'hF);
        i_x = 4'b0000;
        steps(20);

        // random activity: slow toggles that sometimes outlast the debounce window, rare resets
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 6) == 0) i_x[c] = ~i_x[c];
            end
            i_rst = ($urandom_range(0, 249) == 0);
            step();
        end
        i_rst = 1'b0;
        steps(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
